display_source_ctrl: RTL and testbench
======================================

// Module: display_source_ctrl
// PURPOSE
//  Sequencer that drives the `seleccion` select of the display data mux.
//  - seleccion=0: RTC readout set (time, date, timer, am/pm).
//  - seleccion=1: user-programming set.
//  Owns the programming session: entry, snapshot of RTC values, inactivity
//  timeout, and the commit handshake to the RTC write controller.
//  Sits between the debounced keypad/edit logic and the RTC read/write controller.
// PARAMETERS
//  TIMEOUT_S    30    seconds of no key activity in EDIT before automatic abort
//  TMO_W        5     width of inactivity counter; must hold TIMEOUT_S
//  ACK_TMO_CYC  1024  clk cycles to wait for wr_ack in COMMIT before error abort
//  ACK_W        10    width of ack watchdog counter; must hold ACK_TMO_CYC-1
// PORTS
//  clk          in   1  system clock; all state updates on rising edge
//  reset        in   1  asynchronous, active-low reset
//  tick_1hz     in   1  one-clk pulse per second (timeout time base)
//  edit_req     in   1  one-clk pulse: enter programming mode
//  edit_done    in   1  one-clk pulse: commit edited values to RTC
//  edit_cancel  in   1  one-clk pulse: leave programming mode, no write
//  activity     in   1  one-clk pulse on any key press (restarts timeout)
//  rtc_busy     in   1  RTC controller mid-transaction (read or write)
//  wr_ack       in   1  one-clk pulse: RTC write of user set completed
//  seleccion    out  1  mux select: 0=RTC set, 1=user set (registered)
//  load_user    out  1  one-clk pulse: copy RTC set into user registers
//  rd_hold      out  1  level: suspend periodic RTC reads
//  wr_req       out  1  level: request RTC write of user set; held until ack/abort
//  edit_active  out  1  level: programming session in progress (LOAD/EDIT/COMMIT)
//  wr_err       out  1  one-clk pulse: commit aborted by ack watchdog
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state=SHOW_RTC; both counters cleared.
//   - All outputs 0, including wr_req; applies mid-COMMIT too.
//  Outputs are registered: they change in the cycle after the state transition.
//  States:
//   - SHOW_RTC: seleccion=0, rd_hold=0.
//     edit_req=1 -> WAIT_RD. Ignores done/cancel/activity.
//   - WAIT_RD: seleccion=0, rd_hold=1, edit_active=1.
//     rtc_busy=0 -> LOAD; otherwise stays. Snapshot is never taken mid-read.
//   - LOAD: one cycle. load_user=1, rd_hold=1, edit_active=1.
//     Unconditionally -> EDIT; inactivity counter cleared.
//   - EDIT: seleccion=1, rd_hold=1, edit_active=1. Priority order:
//      1. edit_cancel -> SHOW_RTC.
//      2. edit_done -> COMMIT; ack watchdog cleared.
//      3. Timeout -> SHOW_RTC.
//     Inactivity counter:
//      - activity clears it; activity wins over tick_1hz in the same cycle.
//      - Otherwise tick_1hz increments it.
//      - Timeout fires when count==TIMEOUT_S-1 and tick_1hz arrives without activity.
//     edit_req in EDIT is ignored.
//   - COMMIT: seleccion=1, rd_hold=1, wr_req=1, edit_active=1.
//     Inputs edit_*, activity and tick_1hz are ignored here.
//     Exits:
//      - wr_ack -> SHOW_RTC; wr_req falls the next cycle.
//      - Watchdog reaches ACK_TMO_CYC-1 with no ack -> SHOW_RTC; wr_err pulses once.
//      - wr_ack on the watchdog's final cycle counts as success (no wr_err).
//  Leaving to SHOW_RTC:
//   - seleccion returns to 0 and rd_hold to 0 in the same cycle.
//   - The first RTC read then refreshes the display.
//  Counters saturate; no wrap-around is possible (cleared on state entry).
//  wr_ack outside COMMIT is ignored.
// STRUCTURE
//  Shared package display_pkg:
//   - State encodings: SHOW_RTC, WAIT_RD, LOAD, EDIT, COMMIT.
//   - Constants SEL_RTC=1'b0, SEL_USER=1'b1.
//  One sub-module: inactivity_timer.
//   - Inputs: clr, activity, tick, TIMEOUT_S.
//   - Output: expired pulse.
//  FSM, output registers and ack watchdog stay in the top module.
// TESTING
//  1. Reset low mid-COMMIT -> wr_req, seleccion, rd_hold drop to 0 immediately;
//     state SHOW_RTC after release.
//  2. edit_req while rtc_busy=1 for 5 cycles -> load_user pulses exactly once,
//     on the cycle after rtc_busy falls; seleccion=1 one cycle later.
//  3. EDIT with TIMEOUT_S=3 and no activity -> returns to seleccion=0 on the
//     3rd tick_1hz; no wr_req.
//     Repeat with activity on the same cycle as the 3rd tick -> stays in EDIT.
//  4. edit_done and edit_cancel in the same cycle -> SHOW_RTC, wr_req never asserts.
//  5. edit_done, wr_ack after 10 cycles -> wr_req high for 10 cycles,
//     seleccion=0 on the next cycle, wr_err=0.
//  6. edit_done, no wr_ack, ACK_TMO_CYC=16 -> wr_req high 16 cycles,
//     single wr_err pulse, seleccion=0.

Source files
------------

// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display source sequencer: sequencer state
// encoding, display mux select values and the per-state output decode.
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [2:0] {
        SHOW_RTC = 3'd0,
        WAIT_RD  = 3'd1,
        LOAD     = 3'd2,
        EDIT     = 3'd3,
        COMMIT   = 3'd4
    } state_t;

    localparam logic SEL_RTC  = 1'b0;
    localparam logic SEL_USER = 1'b1;

    // Level outputs that depend only on the state being entered.
    typedef struct packed {
        logic seleccion;
        logic load_user;
        logic rd_hold;
        logic wr_req;
        logic edit_active;
    } state_outs_t;

    // The display only switches to the user set once the snapshot has been
    // loaded, so WAIT_RD and LOAD still show the RTC set while reads are held.
    function automatic state_outs_t state_outputs(input state_t s);
        state_outs_t o;
        o = '{seleccion: SEL_RTC, load_user: 1'b0, rd_hold: 1'b0,
              wr_req: 1'b0, edit_active: 1'b0};
        case (s)
            WAIT_RD: begin
                o.rd_hold     = 1'b1;
                o.edit_active = 1'b1;
            end
            LOAD: begin
                o.load_user   = 1'b1;
                o.rd_hold     = 1'b1;
                o.edit_active = 1'b1;
            end
            EDIT: begin
                o.seleccion   = SEL_USER;
                o.rd_hold     = 1'b1;
                o.edit_active = 1'b1;
            end
            COMMIT: begin
                o.seleccion   = SEL_USER;
                o.rd_hold     = 1'b1;
                o.wr_req      = 1'b1;
                o.edit_active = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// ---------------------------------------------------------------------------
// inactivity_timer
// Counts seconds without key activity while a programming session is open.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-low reset
//   clr      in  hold the count at zero (asserted whenever not editing)
//   activity in  key press, restarts the count
//   tick     in  one-clk pulse per second
//   expired  out combinational pulse on the tick that completes TIMEOUT_S
//                idle seconds (suppressed by activity in the same cycle)
// ---------------------------------------------------------------------------
module inactivity_timer
    import display_pkg::*;
#(
    parameter int TIMEOUT_S = 30,
    parameter int TMO_W     = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic activity,
    input  logic tick,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_S - 1);

    logic [TMO_W-1:0] count;

    // Saturates at LAST; the sequencer leaves EDIT on expiry, which clears
    // the count again through clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr || activity) begin
            count <= '0;
        end else if (tick && (count != LAST)) begin
            count <= count + TMO_W'(1);
        end
    end

    // Combinational so the sequencer can leave EDIT on the expiring tick.
    assign expired = !clr && !activity && tick && (count == LAST);

endmodule

// File: rtl/display_source_ctrl.sv
// ---------------------------------------------------------------------------
// display_source_ctrl
// Sequencer for the display data mux select and the user programming
// session: entry, RTC snapshot, inactivity abort and write commit handshake.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   tick_1hz     one-clk pulse per second
//   edit_req     enter programming mode
//   edit_done    commit edited values to the RTC
//   edit_cancel  leave programming mode without writing
//   activity     any key press (restarts the inactivity timeout)
//   rtc_busy     RTC controller mid-transaction
//   wr_ack       RTC write of the user set completed
//   seleccion    mux select: 0 = RTC set, 1 = user set
//   load_user    pulse: copy the RTC set into the user registers
//   rd_hold      suspend periodic RTC reads
//   wr_req       request RTC write of the user set, held until ack/abort
//   edit_active  programming session in progress
//   wr_err       pulse: commit abandoned by the ack watchdog
// All outputs are registered from the state being entered.
// ---------------------------------------------------------------------------
module display_source_ctrl
    import display_pkg::*;
#(
    parameter int TIMEOUT_S   = 30,
    parameter int TMO_W       = 5,
    parameter int ACK_TMO_CYC = 1024,
    parameter int ACK_W       = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1hz,
    input  logic edit_req,
    input  logic edit_done,
    input  logic edit_cancel,
    input  logic activity,
    input  logic rtc_busy,
    input  logic wr_ack,
    output logic seleccion,
    output logic load_user,
    output logic rd_hold,
    output logic wr_req,
    output logic edit_active,
    output logic wr_err
);

    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TMO_CYC - 1);

    state_t           state;
    state_t           next_state;
    state_outs_t      next_outs;
    logic [ACK_W-1:0] ack_cnt;
    logic             ack_tmo;
    logic             tmo_expired;

    inactivity_timer #(
        .TIMEOUT_S (TIMEOUT_S),
        .TMO_W     (TMO_W)
    ) u_inactivity_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (state != EDIT),
        .activity (activity),
        .tick     (tick_1hz),
        .expired  (tmo_expired)
    );

    // Next-state decision. In EDIT cancel beats done beats timeout; in
    // COMMIT an ack on the watchdog's last cycle still counts as success.
    always_comb begin
        next_state = state;
        ack_tmo    = 1'b0;
        case (state)
            SHOW_RTC: if (edit_req) next_state = WAIT_RD;
            WAIT_RD:  if (!rtc_busy) next_state = LOAD;
            LOAD:     next_state = EDIT;
            EDIT: begin
                if (edit_cancel)      next_state = SHOW_RTC;
                else if (edit_done)   next_state = COMMIT;
                else if (tmo_expired) next_state = SHOW_RTC;
            end
            COMMIT: begin
                if (wr_ack) begin
                    next_state = SHOW_RTC;
                end else if (ack_cnt == ACK_LAST) begin
                    next_state = SHOW_RTC;
                    ack_tmo    = 1'b1;
                end
            end
            default: next_state = SHOW_RTC;
        endcase
        next_outs = state_outputs(next_state);
    end

    // State, output registers and ack watchdog. The watchdog is held at zero
    // outside COMMIT so every commit attempt starts a fresh window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SHOW_RTC;
            ack_cnt     <= '0;
            seleccion   <= SEL_RTC;
            load_user   <= 1'b0;
            rd_hold     <= 1'b0;
            wr_req      <= 1'b0;
            edit_active <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            state       <= next_state;
            seleccion   <= next_outs.seleccion;
            load_user   <= next_outs.load_user;
            rd_hold     <= next_outs.rd_hold;
            wr_req      <= next_outs.wr_req;
            edit_active <= next_outs.edit_active;
            wr_err      <= ack_tmo;
            if (state != COMMIT) begin
                ack_cnt <= '0;
            end else if (ack_cnt != ACK_LAST) begin
                ack_cnt <= ack_cnt + ACK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_display_source_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_source_ctrl
// Self-checking bench: a session-level reference model runs alongside the
// DUT and is compared every cycle; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_display_source_ctrl;

    localparam int TIMEOUT_S   = 3;
    localparam int ACK_TMO_CYC = 16;

    localparam logic [6:0] REQ    = 7'h40;
    localparam logic [6:0] DONE   = 7'h20;
    localparam logic [6:0] CANCEL = 7'h10;
    localparam logic [6:0] ACT    = 7'h08;
    localparam logic [6:0] TICK   = 7'h04;
    localparam logic [6:0] BUSY   = 7'h02;
    localparam logic [6:0] ACK    = 7'h01;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick_1hz = 1'b0, edit_req = 1'b0, edit_done = 1'b0, edit_cancel = 1'b0;
    logic activity = 1'b0, rtc_busy = 1'b0, wr_ack = 1'b0;
    logic seleccion, load_user, rd_hold, wr_req, edit_active, wr_err;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    display_source_ctrl #(
        .TIMEOUT_S   (TIMEOUT_S),
        .TMO_W       (5),
        .ACK_TMO_CYC (ACK_TMO_CYC),
        .ACK_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .edit_req    (edit_req),
        .edit_done   (edit_done),
        .edit_cancel (edit_cancel),
        .activity    (activity),
        .rtc_busy    (rtc_busy),
        .wr_ack      (wr_ack),
        .seleccion   (seleccion),
        .load_user   (load_user),
        .rd_hold     (rd_hold),
        .wr_req      (wr_req),
        .edit_active (edit_active),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    // Reference model: which phase of a programming session we are in,
    // how many idle seconds have passed and how many cycles the write has
    // gone unacknowledged.
    typedef enum int {M_IDLE, M_WAIT, M_SNAP, M_EDIT, M_WRITE} mphase_t;
    mphase_t m_ph = M_IDLE;
    int      m_secs = 0;
    int      m_wait = 0;
    logic    m_err = 1'b0;
    logic [5:0] exp_vec;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph   <= M_IDLE;
            m_secs <= 0;
            m_wait <= 0;
            m_err  <= 1'b0;
        end else begin
            m_err <= 1'b0;
            case (m_ph)
                M_IDLE: if (edit_req) m_ph <= M_WAIT;
                M_WAIT: if (!rtc_busy) m_ph <= M_SNAP;
                M_SNAP: begin
                    m_ph   <= M_EDIT;
                    m_secs <= 0;
                end
                M_EDIT: begin
                    if (edit_cancel) begin
                        m_ph <= M_IDLE;
                    end else if (edit_done) begin
                        m_ph   <= M_WRITE;
                        m_wait <= 0;
                    end else if (activity) begin
                        m_secs <= 0;
                    end else if (tick_1hz) begin
                        if (m_secs + 1 == TIMEOUT_S) m_ph <= M_IDLE;
                        else m_secs <= m_secs + 1;
                    end
                end
                M_WRITE: begin
                    if (wr_ack) begin
                        m_ph <= M_IDLE;
                    end else if (m_wait + 1 == ACK_TMO_CYC) begin
                        m_ph  <= M_IDLE;
                        m_err <= 1'b1;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    // Expected {seleccion, load_user, rd_hold, wr_req, edit_active, wr_err}.
    always_comb begin
        exp_vec = '0;
        exp_vec[5] = (m_ph == M_EDIT) || (m_ph == M_WRITE);
        exp_vec[4] = (m_ph == M_SNAP);
        exp_vec[3] = (m_ph != M_IDLE);
        exp_vec[2] = (m_ph == M_WRITE);
        exp_vec[1] = (m_ph != M_IDLE);
        exp_vec[0] = m_err;
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({seleccion, load_user, rd_hold, wr_req, edit_active, wr_err} !== exp_vec) begin
                errors++;
                $display("[TB] FAIL model_cmp at %0t: got %b, expected %b", $time,
                         {seleccion, load_user, rd_hold, wr_req, edit_active, wr_err}, exp_vec);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs starting at a falling edge and returns at
    // the next falling edge, when the DUT's response is visible.
    task automatic applyStimulus(input logic [6:0] v);
        {edit_req, edit_done, edit_cancel, activity, tick_1hz, rtc_busy, wr_ack} = v;
        @(negedge clk);
    endtask

    task automatic enterEdit();
        applyStimulus(REQ);
        applyStimulus('0);
        applyStimulus('0);
        checkOutput("enter_edit_sel", int'(seleccion), 1);
    endtask

    int n;
    int e;

    initial begin
        // Reset values
        #1;
        checkOutput("reset_all_outputs",
                    int'({seleccion, load_user, rd_hold, wr_req, edit_active, wr_err}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Idle state ignores everything except edit_req
        applyStimulus(DONE | CANCEL | ACT | TICK | ACK);
        checkOutput("idle_ignores",
                    int'({seleccion, load_user, rd_hold, wr_req, edit_active, wr_err}), 0);

        // Entry while the RTC is busy for 5 cycles
        applyStimulus(REQ | BUSY);
        checkOutput("wait_rd_hold", int'(rd_hold), 1);
        n = int'(load_user);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(BUSY);
            n += int'(load_user);
        end
        checkOutput("no_load_while_busy", n, 0);
        applyStimulus('0);
        checkOutput("load_after_busy_falls", int'(load_user), 1);
        checkOutput("sel_during_load", int'(seleccion), 0);
        applyStimulus('0);
        checkOutput("load_single_pulse", int'(load_user), 0);
        checkOutput("sel_user_after_load", int'(seleccion), 1);
        applyStimulus(CANCEL);
        checkOutput("cancel_sel", int'(seleccion), 0);
        checkOutput("cancel_rd_hold", int'(rd_hold), 0);

        // Inactivity timeout on the 3rd tick
        enterEdit();
        applyStimulus(TICK);
        applyStimulus('0);
        applyStimulus(TICK);
        applyStimulus('0);
        checkOutput("edit_after_2_ticks", int'(seleccion), 1);
        applyStimulus(TICK);
        checkOutput("timeout_sel", int'(seleccion), 0);
        checkOutput("timeout_no_wr_req", int'(wr_req), 0);

        // Activity on the 3rd tick restarts the count
        enterEdit();
        applyStimulus(TICK);
        applyStimulus(TICK);
        applyStimulus(TICK | ACT);
        checkOutput("activity_keeps_edit", int'(seleccion), 1);
        applyStimulus(TICK);
        applyStimulus(TICK);
        checkOutput("count_restarted", int'(seleccion), 1);
        applyStimulus(TICK);
        checkOutput("timeout_after_restart", int'(seleccion), 0);

        // Done and cancel together: cancel wins
        enterEdit();
        applyStimulus(DONE | CANCEL);
        n = int'(wr_req);
        for (int i = 0; i < 3; i++) begin
            applyStimulus('0);
            n += int'(wr_req);
        end
        checkOutput("done_cancel_sel", int'(seleccion), 0);
        checkOutput("done_cancel_no_wr_req", n, 0);

        // Commit acknowledged after 10 cycles
        enterEdit();
        applyStimulus(DONE);
        n = int'(wr_req);
        for (int i = 0; i < 9; i++) begin
            applyStimulus('0);
            n += int'(wr_req);
        end
        checkOutput("ack10_wr_req_cycles", n, 10);
        applyStimulus(ACK);
        checkOutput("ack10_wr_req_low", int'(wr_req), 0);
        checkOutput("ack10_sel", int'(seleccion), 0);
        checkOutput("ack10_no_err", int'(wr_err), 0);

        // Ack on the watchdog's last cycle is a success
        enterEdit();
        applyStimulus(DONE);
        for (int i = 0; i < 15; i++) applyStimulus('0);
        applyStimulus(ACK);
        checkOutput("ack_last_no_err", int'(wr_err), 0);
        checkOutput("ack_last_wr_req_low", int'(wr_req), 0);

        // No ack: watchdog abort after 16 cycles
        enterEdit();
        applyStimulus(DONE);
        n = int'(wr_req);
        e = int'(wr_err);
        for (int i = 0; i < 20; i++) begin
            applyStimulus('0);
            n += int'(wr_req);
            e += int'(wr_err);
        end
        checkOutput("wdog_wr_req_cycles", n, 16);
        checkOutput("wdog_err_pulses", e, 1);
        checkOutput("wdog_sel", int'(seleccion), 0);

        // Stray ack outside COMMIT
        applyStimulus(ACK);
        checkOutput("stray_ack",
                    int'({seleccion, load_user, rd_hold, wr_req, edit_active, wr_err}), 0);

        // Reset asserted mid-COMMIT
        enterEdit();
        applyStimulus(DONE);
        for (int i = 0; i < 3; i++) applyStimulus('0);
        checkOutput("pre_reset_wr_req", int'(wr_req), 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_wr_req", int'(wr_req), 0);
        checkOutput("async_reset_sel", int'(seleccion), 0);
        checkOutput("async_reset_rd_hold", int'(rd_hold), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus('0);
        checkOutput("post_reset_idle", int'({seleccion, rd_hold, edit_active}), 0);
        applyStimulus(REQ);
        checkOutput("post_reset_entry", int'({seleccion, rd_hold, edit_active}), 3);
        applyStimulus('0);
        checkOutput("post_reset_load", int'(load_user), 1);
        applyStimulus('0);
        applyStimulus(CANCEL);
        applyStimulus('0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
